// File: rtl/sp_ram_bist.sv
// March-style BIST for a single-port 32-bit RAM. It runs W0, R0W1, R1W0 and R0 over NUM_WORDS
// words and passes functional accesses straight through to the RAM while the test is idle.
module sp_ram_bist #(
  parameter int unsigned NUM_WORDS  = 8192,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [31:0] PATTERN    = 32'hA5A5_A5A5
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [7:0]            err_cnt_o,
  input  logic                  func_en_i,
  input  logic [ADDR_WIDTH-1:0] func_addr_i,
  input  logic [31:0]           func_wdata_i,
  input  logic                  func_we_i,
  input  logic [3:0]            func_be_i,
  output logic [31:0]           func_rdata_o,
  output logic                  func_stall_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int unsigned       IDX_W    = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, W0, R0W1_R, R0W1_W, R1W0_R, R1W0_W, R0, DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    cmp_vld_q, cmp_vld_d;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic [31:0]             cmp_exp_q, cmp_exp_d;

  logic                    eng_we;
  logic                    eng_rd;
  logic [31:0]             eng_wdata;
  logic [31:0]             eng_exp;
  logic                    busy;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    err_cnt_d   = err_cnt_q;
    cmp_vld_d   = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    cmp_exp_d   = cmp_exp_q;
    eng_we      = 1'b0;
    eng_rd      = 1'b0;
    eng_wdata   = PATTERN;
    eng_exp     = PATTERN;

    // Read data returns one cycle after the read, so the compare works on the registered stage.
    if (cmp_vld_q && (ram_rdata_i != cmp_exp_q)) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = cmp_addr_q;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          err_cnt_d   = '0;
          idx_d       = '0;
          state_d     = W0;
        end
      end
      W0: begin
        eng_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = R0W1_R;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      R0W1_R: begin
        eng_rd  = 1'b1;
        state_d = R0W1_W;
      end
      R0W1_W: begin
        eng_we    = 1'b1;
        eng_wdata = ~PATTERN;
        if (idx_q == LAST_IDX) begin
          state_d = R1W0_R;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = R0W1_R;
        end
      end
      R1W0_R: begin
        eng_rd  = 1'b1;
        eng_exp = ~PATTERN;
        state_d = R1W0_W;
      end
      R1W0_W: begin
        eng_we = 1'b1;
        if (idx_q == '0) begin
          idx_d   = LAST_IDX;
          state_d = R0;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = R1W0_R;
        end
      end
      R0: begin
        eng_rd = 1'b1;
        if (idx_q == '0) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (eng_rd) begin
      cmp_vld_d  = 1'b1;
      cmp_addr_d = {idx_q, 2'b00};
      cmp_exp_d  = eng_exp;
    end
  end

  // NOTE: state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      err_cnt_q   <= err_cnt_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    if (busy) begin
      ram_en_o     = 1'b1;
      ram_addr_o   = {idx_q, 2'b00};
      ram_wdata_o  = eng_wdata;
      ram_we_o     = eng_we;
      ram_be_o     = 4'hF;
      func_stall_o = 1'b1;
    end else begin
      ram_en_o     = func_en_i;
      ram_addr_o   = func_addr_i;
      ram_wdata_o  = func_wdata_i;
      ram_we_o     = func_we_i;
      ram_be_o     = func_be_i;
      func_stall_o = 1'b0;
    end
  end

  assign busy_o       = busy;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign fail_addr_o  = fail_addr_q;
  assign err_cnt_o    = err_cnt_q;
  assign func_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Self-checking bench for sp_ram_bist: a behavioural RAM with injectable stuck-at faults, plus a
// march-sequence model that predicts every engine access and the final status.
module tb_sp_ram_bist;

  localparam int          AW    = 15;
  localparam int          NA    = 4;
  localparam int          NB    = 200;
  // Bit 0 of this background is 0, so a bit-0 stuck-at-1 shows up on the PATTERN reads.
  localparam logic [31:0] PAT_A = 32'h5A5A_5A5A;
  localparam logic [31:0] PAT_B = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instance A: NUM_WORDS=4
  logic          a_rstn, a_start, a_busy, a_done, a_fail, a_stall;
  logic [AW-1:0] a_fail_addr, a_func_addr, a_ram_addr;
  logic [7:0]    a_err;
  logic          a_func_en, a_func_we, a_ram_en, a_ram_we;
  logic [31:0]   a_func_wdata, a_func_rdata, a_ram_wdata, a_ram_rdata;
  logic [3:0]    a_func_be, a_ram_be;

  sp_ram_bist #(.NUM_WORDS(NA), .ADDR_WIDTH(AW), .PATTERN(PAT_A)) dut_a (
    .clk(clk), .rstn_i(a_rstn), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .fail_o(a_fail), .fail_addr_o(a_fail_addr), .err_cnt_o(a_err),
    .func_en_i(a_func_en), .func_addr_i(a_func_addr), .func_wdata_i(a_func_wdata),
    .func_we_i(a_func_we), .func_be_i(a_func_be), .func_rdata_o(a_func_rdata),
    .func_stall_o(a_stall),
    .ram_en_o(a_ram_en), .ram_addr_o(a_ram_addr), .ram_wdata_o(a_ram_wdata),
    .ram_we_o(a_ram_we), .ram_be_o(a_ram_be), .ram_rdata_i(a_ram_rdata)
  );

  // Instance B: NUM_WORDS=200
  logic          b_rstn, b_start, b_busy, b_done, b_fail, b_stall;
  logic [AW-1:0] b_fail_addr, b_func_addr, b_ram_addr;
  logic [7:0]    b_err;
  logic          b_func_en, b_func_we, b_ram_en, b_ram_we;
  logic [31:0]   b_func_wdata, b_func_rdata, b_ram_wdata, b_ram_rdata;
  logic [3:0]    b_func_be, b_ram_be;

  sp_ram_bist #(.NUM_WORDS(NB), .ADDR_WIDTH(AW), .PATTERN(PAT_B)) dut_b (
    .clk(clk), .rstn_i(b_rstn), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .fail_o(b_fail), .fail_addr_o(b_fail_addr), .err_cnt_o(b_err),
    .func_en_i(b_func_en), .func_addr_i(b_func_addr), .func_wdata_i(b_func_wdata),
    .func_we_i(b_func_we), .func_be_i(b_func_be), .func_rdata_o(b_func_rdata),
    .func_stall_o(b_stall),
    .ram_en_o(b_ram_en), .ram_addr_o(b_ram_addr), .ram_wdata_o(b_ram_wdata),
    .ram_we_o(b_ram_we), .ram_be_o(b_ram_be), .ram_rdata_i(b_ram_rdata)
  );

  // Behavioural RAMs; faults act on the read path only.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  bit          a_fault = 1'b0;
  bit          b_fault = 1'b0;

  always @(posedge clk) begin
    if (a_ram_en) begin
      if (a_ram_we) begin
        for (int k = 0; k < 4; k++)
          if (a_ram_be[k]) mem_a[a_ram_addr[9:2]][8*k +: 8] <= a_ram_wdata[8*k +: 8];
      end else begin
        a_ram_rdata <= (a_fault && a_ram_addr[9:2] == 8'd2) ? (mem_a[a_ram_addr[9:2]] | 32'h1)
                                                             : mem_a[a_ram_addr[9:2]];
      end
    end
  end

  always @(posedge clk) begin
    if (b_ram_en) begin
      if (b_ram_we) begin
        for (int k = 0; k < 4; k++)
          if (b_ram_be[k]) mem_b[b_ram_addr[9:2]][8*k +: 8] <= b_ram_wdata[8*k +: 8];
      end else begin
        b_ram_rdata <= b_fault ? 32'h0 : mem_b[b_ram_addr[9:2]];
      end
    end
  end

  // March model for instance A: ordered list of expected engine accesses plus predicted status.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } op_t;

  op_t           exp_q[$];
  op_t           cur_op;
  logic [31:0]   mm [256];
  bit            armed = 1'b0;
  int            exp_err;
  bit            exp_fail;
  logic [AW-1:0] exp_faddr;

  task automatic model_write(input int i, input logic [31:0] v);
    mm[i] = v;
    exp_q.push_back('{1'b1, AW'(i * 4), v});
  endtask

  task automatic model_read(input int i, input logic [31:0] expv, input bit fault);
    logic [31:0] obs;
    obs = (fault && i == 2) ? (mm[i] | 32'h1) : mm[i];
    exp_q.push_back('{1'b0, AW'(i * 4), expv});
    if (obs != expv) begin
      if (!exp_fail) exp_faddr = AW'(i * 4);
      exp_fail = 1'b1;
      if (exp_err < 255) exp_err++;
    end
  endtask

  task automatic build_model(input int n, input logic [31:0] p, input bit fault);
    exp_q.delete();
    exp_err   = 0;
    exp_fail  = 1'b0;
    exp_faddr = '0;
    for (int i = 0; i < n; i++) model_write(i, p);
    for (int i = 0; i < n; i++) begin model_read(i, p, fault);  model_write(i, ~p); end
    for (int i = n - 1; i >= 0; i--) begin model_read(i, ~p, fault); model_write(i, p); end
    for (int i = n - 1; i >= 0; i--) model_read(i, p, fault);
  endtask

  // Per-cycle compare of instance A engine accesses against the model.
  always @(posedge clk) begin
    #1;
    if (armed) begin
      if (exp_q.size() > 0) begin
        cur_op = exp_q.pop_front();
        check("eng_busy", a_busy, 1'b1);
        check("eng_stall", a_stall, 1'b1);
        check("eng_en", a_ram_en, 1'b1);
        check("eng_be", a_ram_be, 4'hF);
        check("eng_we", a_ram_we, cur_op.we);
        check("eng_addr", a_ram_addr, cur_op.addr);
        if (cur_op.we) check("eng_wdata", a_ram_wdata, cur_op.data);
      end else begin
        check("drain_busy", a_busy, 1'b1);
        armed = 1'b0;
      end
    end
  end

  task automatic run_a(input bit fault, input int restart_at, input int reset_at,
                       output int busy_cycles);
    a_fault = fault;
    build_model(NA, PAT_A, fault);
    @(negedge clk);
    a_start = 1'b1;
    armed   = 1'b1;
    @(negedge clk);
    a_start     = 1'b0;
    busy_cycles = 0;
    while (a_busy && busy_cycles < 6 * NA + 10) begin
      busy_cycles++;
      if (busy_cycles == 1) check("done_cleared_on_start", a_done, 1'b0);
      a_start = (busy_cycles == restart_at);
      if (busy_cycles == reset_at) begin
        a_rstn = 1'b0;
        armed  = 1'b0;
        exp_q.delete();
      end
      @(negedge clk);
    end
    a_start = 1'b0;
    if (reset_at == 0) check("model_drained", exp_q.size(), 0);
    armed = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_a_status(input string tag, input bit fail, input logic [AW-1:0] faddr,
                                input logic [7:0] err);
    check({tag, "_busy"}, a_busy, 1'b0);
    check({tag, "_done"}, a_done, 1'b1);
    check({tag, "_fail"}, a_fail, fail);
    check({tag, "_faddr"}, a_fail_addr, faddr);
    check({tag, "_err"}, a_err, err);
    check({tag, "_model_fail"}, a_fail, exp_fail);
    check({tag, "_model_faddr"}, a_fail_addr, exp_faddr);
    check({tag, "_model_err"}, a_err, exp_err);
  endtask

  task automatic pt_access(input logic [AW-1:0] addr, input logic we, input logic [31:0] wd,
                           input logic [3:0] be);
    a_func_en    = 1'b1;
    a_func_addr  = addr;
    a_func_we    = we;
    a_func_wdata = wd;
    a_func_be    = be;
  endtask

  int bc;

  initial begin
    a_rstn = 1'b0; a_start = 1'b0;
    a_func_en = 1'b0; a_func_addr = '0; a_func_wdata = '0; a_func_we = 1'b0; a_func_be = '0;
    b_rstn = 1'b0; b_start = 1'b0;
    b_func_en = 1'b0; b_func_addr = '0; b_func_wdata = '0; b_func_we = 1'b0; b_func_be = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_fail", a_fail, 1'b0);
    check("rst_faddr", a_fail_addr, '0);
    check("rst_err", a_err, 8'h00);
    check("rst_stall", a_stall, 1'b0);
    check("rst_b_busy", b_busy, 1'b0);
    check("rst_b_stall", b_stall, 1'b0);
    a_rstn = 1'b1;
    b_rstn = 1'b1;

    // Idle passthrough: clear word 4, then a half-word write of DEADBEEF, then read it back.
    @(negedge clk);
    pt_access(15'h0010, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    pt_access(15'h0010, 1'b1, 32'hDEAD_BEEF, 4'h3);
    #1;
    check("pt_en", a_ram_en, 1'b1);
    check("pt_addr", a_ram_addr, 15'h0010);
    check("pt_wdata", a_ram_wdata, 32'hDEAD_BEEF);
    check("pt_we", a_ram_we, 1'b1);
    check("pt_be", a_ram_be, 4'h3);
    check("pt_stall", a_stall, 1'b0);
    @(negedge clk);
    pt_access(15'h0010, 1'b0, 32'h0, 4'hF);
    #1;
    check("pt_rd_we", a_ram_we, 1'b0);
    @(negedge clk);
    a_func_en = 1'b0;
    check("pt_rdata", a_func_rdata, 32'h0000_BEEF);
    check("pt_rdata_mirror", a_func_rdata, a_ram_rdata);

    // Clean RAM
    run_a(1'b0, 0, 0, bc);
    check("clean_busy_cycles", bc, 25);
    check_a_status("clean", 1'b0, 15'h0, 8'h00);
    repeat (3) @(negedge clk);
    check("clean_done_held", a_done, 1'b1);

    // Word 2 bit 0 stuck-at-1
    run_a(1'b1, 0, 0, bc);
    check("sa1_busy_cycles", bc, 25);
    check_a_status("sa1", 1'b1, 15'h0008, 8'h02);
    repeat (2) @(negedge clk);
    check("sa1_err_held", a_err, 8'h02);
    a_fault = 1'b0;

    // Restart pulse at cycle 5 must be ignored
    run_a(1'b0, 5, 0, bc);
    check("restart_busy_cycles", bc, 25);
    check_a_status("restart", 1'b0, 15'h0, 8'h00);

    // Reset at cycle 10
    run_a(1'b0, 0, 10, bc);
    check("rstmid_cycle", bc, 10);
    check("rstmid_busy", a_busy, 1'b0);
    check("rstmid_done", a_done, 1'b0);
    check("rstmid_fail", a_fail, 1'b0);
    check("rstmid_faddr", a_fail_addr, '0);
    check("rstmid_err", a_err, 8'h00);
    check("rstmid_stall", a_stall, 1'b0);
    a_rstn = 1'b1;
    pt_access(15'h0014, 1'b1, 32'h1234_5678, 4'hF);
    #1;
    check("rstmid_pt_addr", a_ram_addr, 15'h0014);
    check("rstmid_pt_we", a_ram_we, 1'b1);
    @(negedge clk);
    pt_access(15'h0014, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    a_func_en = 1'b0;
    check("rstmid_pt_rdata", a_func_rdata, 32'h1234_5678);

    // NUM_WORDS=200 with every bit stuck-at-0
    b_fault = 1'b1;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    bc = 0;
    while (b_busy && bc < 6 * NB + 10) begin
      bc++;
      @(negedge clk);
    end
    check("sa0_busy_cycles", bc, 6 * NB + 1);
    check("sa0_done", b_done, 1'b1);
    check("sa0_fail", b_fail, 1'b1);
    check("sa0_faddr", b_fail_addr, 15'h0000);
    check("sa0_err", b_err, 8'hFF);
    check("sa0_rdata_mirror", b_func_rdata, b_ram_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
